bist_sequencer: RTL
===================

Name: bist_sequencer

Overview:
Automatic scheduler for the BIST LED pattern datapath (ring counter, Johnson counter, LFSR).
- On start, runs each enabled pattern engine in turn: ring, then Johnson, then LFSR.
- Each phase lasts a fixed number of prescaled steps.
- Drives exactly one engine's enable, seed-load and step-advance at a time, then reports done.
- Replaces manual mode selection when a self-running test is wanted.

Parameters:
PRESCALE, 25000000, clk cycles per step tick; legal range >=1 (1 = tick every cycle)
DWELL, 8, step ticks spent in each phase; legal range >=1

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  level; begin a sequence when sampled high in IDLE or DONE
abort  input  1  level; return to IDLE from any state, wins over start
phase_mask  input  3  bit0=ring, bit1=johnson, bit2=lfsr; sampled only on the accepted start cycle
ring_counter_enable  output  1  high during LOAD_RING and RUN_RING
johnson_counter_enable  output  1  high during LOAD_JOHN and RUN_JOHN
lfsr_enable  output  1  high during LOAD_LFSR and RUN_LFSR
load  output  1  one-cycle pulse in every LOAD_* state (engine loads its seed)
step  output  1  one-cycle pulse per prescaled tick in RUN_* (engine advances)
phase  output  2  00 idle/done, 01 ring, 10 johnson, 11 lfsr
busy  output  1  high in any LOAD_*/RUN_* state
done  output  1  high in DONE

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE, all outputs 0, phase=00, prescaler=0, dwell counter=0, latched mask=000.
- States: IDLE, LOAD_RING, RUN_RING, LOAD_JOHN, RUN_JOHN, LOAD_LFSR, RUN_LFSR, DONE.
- All outputs are Moore: decoded from registered state and counters only.
- IDLE or DONE with start=1 and abort=0:
  - Latch phase_mask.
  - Go to the LOAD state of the lowest set mask bit.
  - If the mask is 000, go directly to DONE (from IDLE or DONE).
- LOAD_x: lasts exactly 1 cycle. Clears prescaler and dwell counter, then goes to RUN_x.
- RUN_x:
  - Prescaler increments each cycle, wrapping at PRESCALE-1.
  - step=1 in the cycle prescaler==PRESCALE-1.
  - Each step increments the dwell counter.
  - On the step where dwell==DWELL-1, the next state is the LOAD of the next set mask bit in the order ring->johnson->lfsr. If no set bit remains, go to DONE.
- Phase length: 1 + DWELL*PRESCALE cycles. First step arrives PRESCALE cycles after entering RUN_x.
- DONE: done=1 held until abort (->IDLE) or start (new sequence, mask re-sampled).
- start while busy: ignored. phase_mask changes while busy: ignored.
- abort=1 in any state: next state IDLE, counters cleared. done is not asserted. An in-flight step is not issued in the cycle after abort.
- At most one engine enable is high in any cycle. load and step are never high together.
- Counter widths are sized with $clog2 of PRESCALE and DWELL; no overflow beyond the terminal value.
- Illegal/unreachable state encodings recover to IDLE on the next cycle.

Optional Feature:
BIST_SEQ_LOOP_EN
- Defined: after the last masked phase completes, the next state is LOAD of the first masked phase instead of DONE. The sequence loops until abort; done is never asserted.
- Undefined: the sequence ends in DONE as described above.

Test Plan:
- PRESCALE=4, DWELL=3, mask=111, pulse start in IDLE:
  - load at cycle 1, enables ring for 13 cycles, then johnson for 13, then lfsr for 13.
  - 3 steps per phase, spaced 4 cycles apart.
  - done rises 39 cycles after the start edge; busy is the exact complement window.
- mask=101, start: ring phase, then directly LOAD_LFSR. johnson_counter_enable is never high; done after 26 cycles.
- mask=000, start in IDLE: done=1 next cycle. No load, step or enable ever asserted.
- Abort during RUN_JOHN after its 2nd step: IDLE next cycle, all outputs 0. A later start restarts from LOAD_RING.
- start and abort high together in IDLE: stays IDLE. In DONE: goes to IDLE with done=0.
- Reset mid RUN_LFSR: next cycle all outputs 0, phase=00. With BIST_SEQ_LOOP_EN and mask=111, after RUN_LFSR the next state is LOAD_RING and done stays 0.

Source files
------------

// File: rtl/bist_sequencer.sv
// BIST pattern scheduler: runs ring, johnson, lfsr engines in turn for a
// fixed number of prescaled steps each, then reports done.
// Ports: clk, rst (sync, active-high), start, abort, phase_mask[2:0];
//   outputs ring_counter_enable, johnson_counter_enable, lfsr_enable,
//   load, step, phase[1:0], busy, done.
// Optional: define BIST_SEQ_LOOP_EN to loop the masked phases until abort.
module bist_sequencer #(
  parameter int PRESCALE = 25000000,
  parameter int DWELL    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] phase_mask,
  output logic       ring_counter_enable,
  output logic       johnson_counter_enable,
  output logic       lfsr_enable,
  output logic       load,
  output logic       step,
  output logic [1:0] phase,
  output logic       busy,
  output logic       done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DMAX = DW'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RING,
    S_RUN_RING,
    S_LOAD_JOHN,
    S_RUN_JOHN,
    S_LOAD_LFSR,
    S_RUN_LFSR,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [DW-1:0] dwell, dwell_d;
  logic [2:0]    mask_q, mask_d;
  logic          tick, last;

  // LOAD state of the lowest set bit; DONE when nothing is set.
  function automatic state_t load_of(input logic [2:0] m);
    state_t s;
    s = S_DONE;
    if (m[2]) s = S_LOAD_LFSR;
    if (m[1]) s = S_LOAD_JOHN;
    if (m[0]) s = S_LOAD_RING;
    return s;
  endfunction

  // Successor once a phase has spent its last step.
  function automatic state_t after(input logic [2:0] rest,
                                   input logic [2:0] m);
    state_t s;
    s = load_of(rest);
`ifdef BIST_SEQ_LOOP_EN
    if (s == S_DONE) s = load_of(m);
`else
    if (m == 3'b000) s = S_DONE;
`endif
    return s;
  endfunction

  assign tick = (presc == PMAX);
  assign last = (dwell == DMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      presc  <= '0;
      dwell  <= '0;
      mask_q <= 3'b000;
    end else begin
      state  <= state_d;
      presc  <= presc_d;
      dwell  <= dwell_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    state_d = state;
    presc_d = presc;
    dwell_d = dwell;
    mask_d  = mask_q;
    if (abort) begin
      state_d = S_IDLE;
      presc_d = '0;
      dwell_d = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          presc_d = '0;
          dwell_d = '0;
          if (start) begin
            mask_d  = phase_mask;
            state_d = load_of(phase_mask);
          end
        end
        S_LOAD_RING, S_LOAD_JOHN, S_LOAD_LFSR: begin
          presc_d = '0;
          dwell_d = '0;
          state_d = state_t'(state + 3'd1);
        end
        S_RUN_RING, S_RUN_JOHN, S_RUN_LFSR: begin
          if (tick) begin
            presc_d = '0;
            if (last) begin
              dwell_d = '0;
              case (state)
                S_RUN_RING: state_d = after(mask_q & 3'b110, mask_q);
                S_RUN_JOHN: state_d = after(mask_q & 3'b100, mask_q);
                default:    state_d = after(3'b000, mask_q);
              endcase
            end else begin
              dwell_d = dwell + 1'b1;
            end
          end else begin
            presc_d = presc + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ring_counter_enable    = 1'b0;
    johnson_counter_enable = 1'b0;
    lfsr_enable            = 1'b0;
    load                   = 1'b0;
    step                   = 1'b0;
    phase                  = 2'b00;
    busy                   = 1'b0;
    done                   = 1'b0;
    case (state)
      S_LOAD_RING, S_RUN_RING: begin
        ring_counter_enable = 1'b1;
        phase               = 2'b01;
      end
      S_LOAD_JOHN, S_RUN_JOHN: begin
        johnson_counter_enable = 1'b1;
        phase                  = 2'b10;
      end
      S_LOAD_LFSR, S_RUN_LFSR: begin
        lfsr_enable = 1'b1;
        phase       = 2'b11;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    case (state)
      S_LOAD_RING, S_LOAD_JOHN, S_LOAD_LFSR: begin
        load = 1'b1;
        busy = 1'b1;
      end
      S_RUN_RING, S_RUN_JOHN, S_RUN_LFSR: begin
        step = tick;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
